// File: rtl/hmc_rf_arb_pkg.sv
// rtl/hmc_rf_arb_pkg.sv - shared types, illegal-address masks and status struct for the RF access arbiter
package hmc_rf_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    // Bit n set means an access of that kind to RF address n is refused locally
    localparam logic [15:0] RF_WR_ILLEGAL_MASK = 16'h1EFB;
    localparam logic [15:0] RF_RD_ILLEGAL_MASK = 16'h0100;

    typedef struct packed {
        logic invalid;
        logic timeout;
    } rsp_status_t;

    // Addresses beyond the mask range are never refused here; the RF decides
    function automatic logic rf_addr_illegal(input logic write, input logic [31:0] addr);
        logic [15:0] mask;
        mask = write ? RF_WR_ILLEGAL_MASK : RF_RD_ILLEGAL_MASK;
        if (addr > 32'd15) begin
            return 1'b0;
        end
        return mask[addr[3:0]];
    endfunction

endpackage

// File: rtl/hmc_rf_rr_arbiter.sv
// rtl/hmc_rf_rr_arbiter.sv - combinational round-robin picker, search starts one above rr_ptr
module hmc_rf_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDW     = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     rr_ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_idx,
    output logic               grant_valid
);

    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    int                   pos;

    // Rotate so bit 0 is the requester right after rr_ptr, then take the lowest set bit
    always_comb begin
        req_dbl     = {req, req} >> (int'(rr_ptr) + 1);
        req_rot     = req_dbl[NUM_REQ-1:0];
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        pos         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!grant_valid && req_rot[i]) begin
                grant_valid = 1'b1;
                pos         = int'(rr_ptr) + 1 + i;
                if (pos >= NUM_REQ) begin
                    pos = pos - NUM_REQ;
                end
                grant_idx = IDW'(pos);
                grant     = NUM_REQ'(1) << pos;
            end
        end
    end

endmodule

// File: rtl/hmc_rf_access_arbiter.sv
// rtl/hmc_rf_access_arbiter.sv - shares one openHMC RF port among NUM_REQ requesters; optional RF_ADDR_PRECHECK_EN
module hmc_rf_access_arbiter #(
    parameter int NUM_REQ       = 2,
    parameter int HMC_RF_AWIDTH = 4,
    parameter int HMC_RF_WWIDTH = 64,
    parameter int HMC_RF_RWIDTH = 64,
    parameter int TIMEOUT_LOG   = 8,
    localparam int IDW          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                               clk_hmc,
    input  logic                               res_hmc,
    input  logic [NUM_REQ-1:0]                 req_valid,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic [NUM_REQ-1:0]                 req_write,
    input  logic [NUM_REQ*HMC_RF_AWIDTH-1:0]   req_address,
    input  logic [NUM_REQ*HMC_RF_WWIDTH-1:0]   req_wdata,
    output logic                               rsp_valid,
    input  logic                               rsp_ready,
    output logic [IDW-1:0]                     rsp_id,
    output logic [HMC_RF_RWIDTH-1:0]           rsp_rdata,
    output logic                               rsp_invalid,
    output logic                               rsp_timeout,
    output logic [HMC_RF_AWIDTH-1:0]           rf_address,
    output logic                               rf_read_en,
    output logic                               rf_write_en,
    output logic [HMC_RF_WWIDTH-1:0]           rf_write_data,
    input  logic [HMC_RF_RWIDTH-1:0]           rf_read_data,
    input  logic                               rf_access_complete,
    input  logic                               rf_invalid_address
);

    import hmc_rf_arb_pkg::*;

    // Last WAIT count value before expiry: the 2**TIMEOUT_LOG-1'th silent WAIT cycle ends the access
    localparam logic [TIMEOUT_LOG-1:0] TO_LAST = TIMEOUT_LOG'((2 ** TIMEOUT_LOG) - 2);

    arb_state_t                 state_q, state_d;
    logic [IDW-1:0]             rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]             id_q, id_d;
    logic                       wr_q, wr_d;
    logic [HMC_RF_AWIDTH-1:0]   addr_q, addr_d;
    logic [HMC_RF_WWIDTH-1:0]   wdata_q, wdata_d;
    logic [TIMEOUT_LOG-1:0]     cnt_q, cnt_d;
    logic                       rd_en_q, rd_en_d;
    logic                       wr_en_q, wr_en_d;
    logic                       rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]             rsp_id_q, rsp_id_d;
    logic [HMC_RF_RWIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    rsp_status_t                rsp_st_q, rsp_st_d;

    logic [NUM_REQ-1:0]         grant;
    logic [IDW-1:0]             grant_idx;
    logic                       grant_valid;
    logic [HMC_RF_AWIDTH-1:0]   addr_arr  [NUM_REQ];
    logic [HMC_RF_WWIDTH-1:0]   wdata_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g]  = req_address[g*HMC_RF_AWIDTH +: HMC_RF_AWIDTH];
        assign wdata_arr[g] = req_wdata[g*HMC_RF_WWIDTH +: HMC_RF_WWIDTH];
    end

    hmc_rf_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_rr (
        .req         (req_valid),
        .rr_ptr      (rr_ptr_q),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // Accept is offered only in IDLE and is forced low while reset is asserted
    assign req_ready     = (state_q == IDLE && !res_hmc) ? grant : '0;
    assign rf_address    = addr_q;
    assign rf_write_data = wdata_q;
    assign rf_read_en    = rd_en_q;
    assign rf_write_en   = wr_en_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_id        = rsp_id_q;
    assign rsp_rdata     = rsp_rdata_q;
    assign rsp_invalid   = rsp_st_q.invalid;
    assign rsp_timeout   = rsp_st_q.timeout;

    // State and capture registers; reset abandons any access in flight
    always_ff @(posedge clk_hmc or posedge res_hmc) begin
        if (res_hmc) begin
            state_q     <= IDLE;
            rr_ptr_q    <= IDW'(NUM_REQ - 1);
            id_q        <= '0;
            wr_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_rdata_q <= '0;
            rsp_st_q    <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            rd_en_q     <= rd_en_d;
            wr_en_q     <= wr_en_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_st_q    <= rsp_st_d;
        end
    end

    // Next-state: grant, one-cycle enable pulse, bounded wait, then hold the response
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        wr_d        = wr_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        rd_en_d     = 1'b0;
        wr_en_d     = 1'b0;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_st_d    = rsp_st_q;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    rr_ptr_d = grant_idx;
                    id_d     = grant_idx;
                    wr_d     = req_write[grant_idx];
                    addr_d   = addr_arr[grant_idx];
                    wdata_d  = wdata_arr[grant_idx];
`ifdef RF_ADDR_PRECHECK_EN
                    if (rf_addr_illegal(req_write[grant_idx], 32'(addr_arr[grant_idx]))) begin
                        state_d          = RESP;
                        rsp_valid_d      = 1'b1;
                        rsp_id_d         = grant_idx;
                        rsp_rdata_d      = '0;
                        rsp_st_d.invalid = 1'b1;
                        rsp_st_d.timeout = 1'b0;
                    end else
`endif
                    begin
                        state_d = ISSUE;
                        rd_en_d = !req_write[grant_idx];
                        wr_en_d = req_write[grant_idx];
                    end
                end
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = '0;
            end
            WAIT: begin
                cnt_d = cnt_q + TIMEOUT_LOG'(1);
                if (rf_access_complete) begin
                    state_d          = RESP;
                    rsp_valid_d      = 1'b1;
                    rsp_id_d         = id_q;
                    rsp_rdata_d      = wr_q ? '0 : rf_read_data;
                    rsp_st_d.invalid = rf_invalid_address;
                    rsp_st_d.timeout = 1'b0;
                end else if (cnt_q == TO_LAST) begin
                    state_d          = RESP;
                    rsp_valid_d      = 1'b1;
                    rsp_id_d         = id_q;
                    rsp_rdata_d      = '0;
                    rsp_st_d.invalid = 1'b0;
                    rsp_st_d.timeout = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_id_d    = '0;
                    rsp_rdata_d = '0;
                    rsp_st_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_hmc_rf_access_arbiter.sv
// tb/tb_hmc_rf_access_arbiter.sv - scoreboard bench for hmc_rf_access_arbiter with a behavioural RF
module tb_hmc_rf_access_arbiter;

    localparam int NR  = 2;
    localparam int AW  = 4;
    localparam int WW  = 64;
    localparam int RW  = 64;
    localparam int TL  = 8;
    localparam int IDW = 1;
    localparam logic [RW-1:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;
`ifdef RF_ADDR_PRECHECK_EN
    localparam bit PRECHK = 1'b1;
`else
    localparam bit PRECHK = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 res_hmc;
    logic [NR-1:0]        req_valid, req_ready, req_write;
    logic [NR*AW-1:0]     req_address;
    logic [NR*WW-1:0]     req_wdata;
    logic                 rsp_valid, rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [RW-1:0]        rsp_rdata;
    logic                 rsp_invalid, rsp_timeout;
    logic [AW-1:0]        rf_address;
    logic                 rf_read_en, rf_write_en;
    logic [WW-1:0]        rf_write_data;
    logic [RW-1:0]        rf_read_data;
    logic                 rf_access_complete, rf_invalid_address;

    hmc_rf_access_arbiter #(
        .NUM_REQ(NR), .HMC_RF_AWIDTH(AW), .HMC_RF_WWIDTH(WW),
        .HMC_RF_RWIDTH(RW), .TIMEOUT_LOG(TL)
    ) dut (
        .clk_hmc(clk), .res_hmc(res_hmc),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_address(req_address), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_rdata(rsp_rdata), .rsp_invalid(rsp_invalid), .rsp_timeout(rsp_timeout),
        .rf_address(rf_address), .rf_read_en(rf_read_en), .rf_write_en(rf_write_en),
        .rf_write_data(rf_write_data), .rf_read_data(rf_read_data),
        .rf_access_complete(rf_access_complete), .rf_invalid_address(rf_invalid_address)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           id;
        logic [RW-1:0] rdata;
        bit           inv;
        bit           to;
    } exp_t;

    exp_t     exp_q[$];
    int       grant_log[$];
    int       hs_log[$];
    int       checks = 0, errors = 0;
    int       cyc = 0, hs_total = 0, hs_cyc = 0, en_cyc = 0, rsp_rise_cyc = 0, rsp_rises = 0;
    int       rd_pulses = 0, wr_pulses = 0, inject_req = 0, inject_done = 0;
    bit       cfg_silent = 0, cfg_inv = 0;
    logic [RW-1:0] cfg_rdata = '0;
    logic [AW-1:0] exp_addr = '0;
    logic [WW-1:0] exp_wdata = '0;
    bit       exp_wr = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit model_illegal(input bit w, input logic [AW-1:0] a);
        if (w) return (a == 4'h0 || a == 4'h1 || (a >= 4'h3 && a <= 4'h7) || (a >= 4'h9 && a <= 4'hC));
        return (a == 4'h8);
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Behavioural RF: completes one cycle after the enable unless silent; also injects stray completions
    initial begin
        bit pend;
        pend = 0;
        rf_access_complete = 0;
        rf_invalid_address = 0;
        rf_read_data = JUNK;
        forever begin
            @(posedge clk); #1;
            rf_access_complete = 0;
            rf_invalid_address = 0;
            rf_read_data = JUNK;
            if (res_hmc) begin
                pend = 0;
            end else if (pend) begin
                rf_access_complete = 1;
                rf_invalid_address = cfg_inv;
                rf_read_data = cfg_rdata;
                pend = 0;
            end else if (inject_req != inject_done) begin
                rf_access_complete = 1;
                inject_done++;
            end
            if ((rf_read_en || rf_write_en) && !cfg_silent && !res_hmc) pend = 1;
        end
    end

    // Monitors: handshakes push expectations, enables are checked, responses are popped
    initial begin
        bit prev_en, prev_rsp, w, ill;
        logic [AW-1:0] a;
        exp_t e;
        prev_en = 0;
        prev_rsp = 0;
        forever begin
            @(negedge clk);
            if (res_hmc) begin
                exp_q.delete();
                prev_en = 0;
                prev_rsp = 0;
            end else begin
                if (req_ready != '0) begin
                    check_eq("ready_onehot", 64'($onehot(req_ready)), 1);
                    check_eq("ready_only_valid", 64'(req_ready & ~req_valid), 0);
                end
                for (int i = 0; i < NR; i++) begin
                    if (req_valid[i] && req_ready[i]) begin
                        w = req_write[i];
                        a = req_address[i*AW +: AW];
                        ill = PRECHK && model_illegal(w, a);
                        e.id = i;
                        e.inv = ill || (!cfg_silent && cfg_inv);
                        e.to = !ill && cfg_silent;
                        e.rdata = (w || ill || cfg_silent) ? '0 : cfg_rdata;
                        exp_q.push_back(e);
                        grant_log.push_back(i);
                        hs_log.push_back(cyc);
                        hs_total++;
                        hs_cyc = cyc;
                        exp_addr = a;
                        exp_wdata = req_wdata[i*WW +: WW];
                        exp_wr = w;
                    end
                end
                if (rf_read_en || rf_write_en) begin
                    check_eq("en_excl", 64'(rf_read_en && rf_write_en), 0);
                    check_eq("en_pulse", 64'(prev_en), 0);
                    check_eq("en_kind", 64'(rf_write_en), 64'(exp_wr));
                    check_eq("rf_addr", 64'(rf_address), 64'(exp_addr));
                    if (rf_write_en) check_eq("rf_wdata", rf_write_data, exp_wdata);
                    en_cyc = cyc;
                    if (rf_read_en) rd_pulses++;
                    if (rf_write_en) wr_pulses++;
                end
                prev_en = rf_read_en || rf_write_en;
                if (rsp_valid && !prev_rsp) begin
                    rsp_rise_cyc = cyc;
                    rsp_rises++;
                end
                prev_rsp = rsp_valid;
                if (rsp_valid && rsp_ready) begin
                    if (exp_q.size() == 0) begin
                        check_eq("rsp_unexpected", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check_eq("rsp_id", 64'(rsp_id), 64'(e.id));
                        check_eq("rsp_rdata", rsp_rdata, e.rdata);
                        check_eq("rsp_invalid", 64'(rsp_invalid), 64'(e.inv));
                        check_eq("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
                    end
                end
            end
        end
    end

    task automatic do_access(input int id, input bit w, input logic [AW-1:0] a, input logic [WW-1:0] d);
        int n, base;
        base = hs_total;
        req_write[id] = w;
        req_address[id*AW +: AW] = a;
        req_wdata[id*WW +: WW] = d;
        req_valid[id] = 1'b1;
        for (n = 0; n < 50; n++) begin
            @(posedge clk); #1;
            if (hs_total != base) break;
        end
        check_eq("hs_bound", 64'(n < 50), 1);
        req_valid[id] = 1'b0;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        for (n = 0; n < bound; n++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !rsp_valid) break;
        end
        check_eq("idle_bound", 64'(n < bound), 1);
        @(posedge clk); #1;
    endtask

    task automatic idle_cycles(input int k);
        for (int i = 0; i < k; i++) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int base, rbase, n;
        res_hmc = 1'b1;
        req_valid = '0;
        req_write = '0;
        req_address = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        idle_cycles(3);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 0);
        check_eq("rst_req_ready", 64'(req_ready), 0);
        check_eq("rst_rd_en", 64'(rf_read_en), 0);
        check_eq("rst_wr_en", 64'(rf_write_en), 0);
        check_eq("rst_rf_addr", 64'(rf_address), 0);
        res_hmc = 1'b0;
        idle_cycles(2);

        // Single read from requester 0 with minimum latency
        cfg_rdata = 64'h0000_0000_DEAD_BEEF;
        base = rd_pulses;
        do_access(0, 1'b0, 4'h2, '0);
        wait_idle(50);
        check_eq("t1_rd_pulses", 64'(rd_pulses - base), 1);
        check_eq("t1_en_lat", 64'(en_cyc - hs_cyc), 1);
        check_eq("t1_rsp_lat", 64'(rsp_rise_cyc - hs_cyc), 3);

        // Silent RF write: timeout, then a stray completion must be ignored
        cfg_silent = 1;
        do_access(1, 1'b1, 4'hD, 64'h1111_2222_3333_4444);
        wait_idle(400);
        check_eq("t3_to_lat", 64'(rsp_rise_cyc - en_cyc), 256);
        cfg_silent = 0;
        rbase = rsp_rises;
        idle_cycles(3);
        inject_req++;
        idle_cycles(12);
        check_eq("t3_late_ignored", 64'(rsp_rises - rbase), 0);

        // Both requesters always valid: alternate grants at minimum turnaround
        cfg_rdata = 64'h0000_0000_DEAD_BEEF;
        req_write[0] = 1'b0; req_address[0*AW +: AW] = 4'h2;
        req_write[1] = 1'b1; req_address[1*AW +: AW] = 4'hD; req_wdata[1*WW +: WW] = 64'hA5A5_5A5A_0F0F_F0F0;
        base = hs_total;
        req_valid = 2'b11;
        for (n = 0; n < 100; n++) begin
            @(posedge clk); #1;
            if (hs_total >= base + 4) break;
        end
        req_valid = 2'b00;
        check_eq("t2_bound", 64'(n < 100), 1);
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("t2_grant%0d", k), 64'(grant_log[grant_log.size()-4+k]), 64'(k % 2));
        end
        for (int k = 1; k < 4; k++) begin
            check_eq($sformatf("t2_gap%0d", k),
                     64'(hs_log[hs_log.size()-4+k] - hs_log[hs_log.size()-5+k]), 4);
        end
        wait_idle(50);

        // Addresses the RF rejects: write 0x3 and read 0x8
        cfg_inv = 1;
        cfg_rdata = 64'h5555_6666_7777_8888;
        base = wr_pulses;
        do_access(0, 1'b1, 4'h3, 64'hCAFE);
        wait_idle(50);
        check_eq("t4_wr_pulses", 64'(wr_pulses - base), PRECHK ? 0 : 1);
        check_eq("t4_wr_lat", 64'(rsp_rise_cyc - hs_cyc), PRECHK ? 1 : 3);
        base = rd_pulses;
        do_access(1, 1'b0, 4'h8, '0);
        wait_idle(50);
        check_eq("t4_rd_pulses", 64'(rd_pulses - base), PRECHK ? 0 : 1);
        cfg_inv = 0;

        // Response back-pressure while requester 1 waits
        rsp_ready = 1'b0;
        cfg_rdata = 64'h0123_4567_89AB_CDEF;
        do_access(0, 1'b0, 4'h2, '0);
        req_write[1] = 1'b0; req_address[1*AW +: AW] = 4'h5;
        req_valid[1] = 1'b1;
        for (n = 0; n < 20; n++) begin
            @(negedge clk);
            if (rsp_valid) break;
        end
        check_eq("t5_bound", 64'(n < 20), 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check_eq("t5_valid", 64'(rsp_valid), 1);
            check_eq("t5_rdata", rsp_rdata, 64'h0123_4567_89AB_CDEF);
            check_eq("t5_id", 64'(rsp_id), 0);
            check_eq("t5_ready", 64'(req_ready), 0);
        end
        @(posedge clk); #1;
        base = hs_total;
        rsp_ready = 1'b1;
        for (n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (hs_total != base) break;
        end
        req_valid[1] = 1'b0;
        check_eq("t5_next_grant", 64'(grant_log[grant_log.size()-1]), 1);
        wait_idle(50);

        // Asynchronous reset in the middle of WAIT
        cfg_silent = 1;
        do_access(0, 1'b0, 4'h2, '0);
        idle_cycles(3);
        req_valid = 2'b11;
        #2;
        res_hmc = 1'b1;
        #1;
        check_eq("t6_rd_en", 64'(rf_read_en), 0);
        check_eq("t6_wr_en", 64'(rf_write_en), 0);
        check_eq("t6_rsp_valid", 64'(rsp_valid), 0);
        check_eq("t6_req_ready", 64'(req_ready), 0);
        check_eq("t6_rf_addr", 64'(rf_address), 0);
        cfg_silent = 0;
        idle_cycles(2);
        base = hs_total;
        res_hmc = 1'b0;
        for (n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (hs_total != base) break;
        end
        req_valid = 2'b00;
        check_eq("t6_bound", 64'(n < 20), 1);
        check_eq("t6_first_grant", 64'(grant_log[grant_log.size()-1]), 0);
        wait_idle(50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
